// File: rtl/sdc_pkg.sv
// Shared SD-card SPI-mode definitions: FSM states, frame geometry, R1 bit
// positions, CRC7 polynomial and common command bytes.
package sdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_NCR,
        ST_RESP
    } sdc_state_e;

    localparam int unsigned FRAME_LEN = 48;

    localparam int unsigned R1_IDLE        = 0;
    localparam int unsigned R1_ERASE_RST   = 1;
    localparam int unsigned R1_ILL_CMD     = 2;
    localparam int unsigned R1_COM_CRC_ERR = 3;
    localparam int unsigned R1_ERASE_SEQ   = 4;
    localparam int unsigned R1_ADDR_ERR    = 5;
    localparam int unsigned R1_PARAM_ERR   = 6;

    // x^7 + x^3 + 1, leading x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic [7:0] CMD0   = 8'h40;
    localparam logic [7:0] CMD8   = 8'h48;
    localparam logic [7:0] CMD55  = 8'h77;
    localparam logic [7:0] ACMD41 = 8'h69;

endpackage

// File: rtl/sdc_crc7.sv
// Serial CRC7 (MSB first) with synchronous clear and bit enable; clear and
// enable in the same cycle restarts the CRC with the presented bit.
module sdc_crc7
    import sdc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_din,
    output logic [6:0] o_crc
);

    logic [6:0] crc_q, crc_d, base;
    logic       fb;

    always_comb begin
        base  = i_clr ? '0 : crc_q;
        crc_d = base;
        fb    = i_din ^ base[6];
        if (i_en) begin
            crc_d = {base[5:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/sdc_spi_responder.sv
// Card-side SPI-mode SD command responder: receives 48-bit frames, returns R1
// after N_CR filler bytes. Optional CRC7 checking under SDC_CRC_CHECK_EN.
module sdc_spi_responder
    import sdc_pkg::*;
#(
    parameter int unsigned N_CR        = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic [7:0]  o_crc,
    output logic        o_cmd_valid,
    input  logic [7:0]  i_r1,
`ifdef SDC_CRC_CHECK_EN
    output logic        o_crc_err,
`endif
    output logic        o_busy
);

    localparam logic [6:0] NCR_LAST = 7'(N_CR * 8 - 1);
    localparam logic [6:0] NCR_END  = 7'(N_CR * 8);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

    sdc_state_e  state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [46:0] shift_q, shift_d;
    logic [6:0]  ncr_cnt_q, ncr_cnt_d;
    logic [7:0]  resp_q, resp_d;
    logic [2:0]  resp_cnt_q, resp_cnt_d;
    logic        miso_q, miso_d;
    logic [7:0]  cmd_q, cmd_d, crc_q, crc_d;
    logic [31:0] arg_q, arg_d;
    logic        valid_q, valid_d;
    logic [47:0] frame;
    logic [7:0]  r1_tx;
    logic        start;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign frame     = {shift_q, mosi_s};
    assign start     = ~cs_s && (state_q == ST_IDLE) && sclk_rise && !mosi_s;

`ifdef SDC_CRC_CHECK_EN
    logic [6:0] crc_calc;
    logic       crc_err_q, crc_err_d;
    logic       crc_en;

    assign crc_en = start || ((state_q == ST_RECV) && sclk_rise && (bit_cnt_q < 6'd40));

    sdc_crc7 u_crc7 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (start),
        .i_en  (crc_en),
        .i_din (mosi_s),
        .o_crc (crc_calc)
    );

    always_comb begin
        crc_err_d = crc_err_q;
        if (~cs_s && (state_q == ST_RECV) && sclk_rise && (bit_cnt_q == 6'd47)) begin
            crc_err_d = (frame[7:1] != crc_calc) || !frame[0];
        end
        r1_tx = i_r1;
        r1_tx[R1_COM_CRC_ERR] = i_r1[R1_COM_CRC_ERR] | crc_err_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    assign o_crc_err = crc_err_q;
`else
    assign r1_tx = i_r1;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ncr_cnt_d  = ncr_cnt_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        miso_d     = miso_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        valid_d    = 1'b0;

        // Deselect overrides every state, including a coincident SCLK edge
        if (cs_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b1;
                    if (start) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = 6'd1;
                        shift_d   = '0;
                    end
                end
                ST_RECV: begin
                    if (sclk_rise) begin
                        shift_d   = frame[46:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd47) begin
                            cmd_d     = frame[47:40];
                            arg_d     = frame[39:8];
                            crc_d     = frame[7:0];
                            valid_d   = 1'b1;
                            ncr_cnt_d = '0;
                            state_d   = ST_NCR;
                        end
                    end
                end
                ST_NCR: begin
                    miso_d = 1'b1;
                    if (sclk_rise && (ncr_cnt_q != NCR_END)) begin
                        ncr_cnt_d = ncr_cnt_q + 7'd1;
                        if (ncr_cnt_q == NCR_LAST) begin
                            resp_d = r1_tx;
                        end
                    end
                    if (sclk_fall && (ncr_cnt_q == NCR_END)) begin
                        miso_d     = resp_q[7];
                        resp_cnt_d = '0;
                        state_d    = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (sclk_fall) begin
                        if (resp_cnt_q == 3'd7) begin
                            miso_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            resp_d     = {resp_q[6:0], 1'b0};
                            miso_d     = resp_q[6];
                            resp_cnt_d = resp_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ncr_cnt_q   <= '0;
            resp_q      <= '0;
            resp_cnt_q  <= '0;
            miso_q      <= 1'b1;
            cmd_q       <= '0;
            arg_q       <= '0;
            crc_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ncr_cnt_q   <= ncr_cnt_d;
            resp_q      <= resp_d;
            resp_cnt_q  <= resp_cnt_d;
            miso_q      <= miso_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            crc_q       <= crc_d;
            valid_q     <= valid_d;
        end
    end

    assign o_miso      = miso_q;
    assign o_cmd       = cmd_q;
    assign o_arg       = arg_q;
    assign o_crc       = crc_q;
    assign o_cmd_valid = valid_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdc_spi_responder.sv
// Bench for sdc_spi_responder: host-side SPI driver, frame scoreboard on
// o_cmd_valid, CRC7 reference by polynomial long division.
module tb_sdc_spi_responder;

    localparam int unsigned TB_NCR  = 8;
    localparam int unsigned TB_SYNC = 2;
    localparam int unsigned HALF    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs, mosi;
    logic        miso;
    logic [7:0]  cmd, crc;
    logic [31:0] arg;
    logic        cmd_valid, busy;
    logic [7:0]  r1;
`ifdef SDC_CRC_CHECK_EN
    logic        crc_err;
`endif

    always #5 clk = ~clk;

    sdc_spi_responder #(
        .N_CR        (TB_NCR),
        .SYNC_STAGES (TB_SYNC)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sclk      (sclk),
        .i_cs        (cs),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_cmd       (cmd),
        .o_arg       (arg),
        .o_crc       (crc),
        .o_cmd_valid (cmd_valid),
        .i_r1        (r1),
`ifdef SDC_CRC_CHECK_EN
        .o_crc_err   (crc_err),
`endif
        .o_busy      (busy)
    );

    typedef struct {
        logic [47:0] f;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned pulses  = 0;
    int unsigned frames  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Remainder of frame_bits(1..40) * x^7 divided by x^7+x^3+1
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic ref_bad(input logic [47:0] f);
        return (f[7:1] != ref_crc7(f[47:8])) || !f[0];
    endfunction

    function automatic logic [7:0] ref_r1(input logic [47:0] f, input logic [7:0] r);
`ifdef SDC_CRC_CHECK_EN
        return ref_bad(f) ? (r | 8'h08) : r;
`else
        return r;
`endif
    endfunction

    // Monitor: pops one expectation per o_cmd_valid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got cmd 0x%0h, expected no pulse", cmd);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd", 64'(cmd), 64'(e.f[47:40]));
                    check("arg", 64'(arg), 64'(e.f[39:8]));
                    check("crc", 64'(crc), 64'(e.f[7:0]));
`ifdef SDC_CRC_CHECK_EN
                    check("crc_err", 64'(crc_err), 64'(e.err));
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic xfer_bit(input logic b, output logic rx);
        mosi = b;
        repeat (HALF) @(negedge clk);
        rx   = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) xfer_bit(tx[i], rx[i]);
    endtask

    // Dummy byte, 48-bit frame, then the N_CR filler bytes
    task automatic send_frame(input logic [47:0] f, input logic [7:0] r1v);
        logic [7:0] rx, acc;
        logic [47:0] fv;
        exp_t e;
        r1    = r1v;
        fv    = f;
        e.f   = f;
        e.err = ref_bad(f);
        exp_q.push_back(e);
        frames++;
        acc = 8'hFF;
        xfer_byte(8'hFF, rx);
        acc &= rx;
        for (int b = 5; b >= 0; b--) begin
            xfer_byte(fv[b*8 +: 8], rx);
            acc &= rx;
        end
        check("miso_idle_frame", 64'(acc), 64'hFF);
        acc = 8'hFF;
        for (int n = 0; n < int'(TB_NCR); n++) begin
            xfer_byte(8'hFF, rx);
            acc &= rx;
        end
        check("ncr_fill", 64'(acc), 64'hFF);
    endtask

    task automatic run_cmd(input logic [47:0] f, input logic [7:0] r1v);
        logic [7:0] rx;
        int unsigned p0;
        p0 = pulses;
        send_frame(f, r1v);
        xfer_byte(8'hFF, rx);
        check("r1", 64'(rx), 64'(ref_r1(f, r1v)));
        xfer_byte(8'hFF, rx);
        check("miso_after_r1", 64'(rx), 64'hFF);
        check("busy_after", 64'(busy), 64'd0);
        check("one_pulse", 64'(pulses - p0), 64'd1);
    endtask

    initial begin
        logic [7:0]  rx;
        logic        bit_rx, acc1;
        logic [47:0] f;
        int unsigned p0;

        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b1; r1 = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso", 64'(miso), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_outs", {cmd, arg, crc}, 64'd0);

        cs = 1'b0;
        repeat (4) @(negedge clk);
        run_cmd(48'h40_00000000_95, 8'h01);
        run_cmd(48'h48_000001AA_87, 8'h01);

        // Abort a CMD0 after 20 bits
        p0 = pulses;
        f  = 48'h40_00000000_95;
        xfer_byte(8'hFF, rx);
        acc1 = 1'b1;
        for (int i = 47; i >= 28; i--) begin
            xfer_bit(f[i], bit_rx);
            acc1 &= bit_rx;
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_miso", 64'(acc1 & miso), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_pulse", 64'(pulses - p0), 64'd0);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        run_cmd(48'h77_00000000_65, 8'h01);

        run_cmd(48'h40_00000000_94, 8'h01);
        run_cmd(48'h40_00000000_95, 8'h01);

        run_cmd(48'h77_00000000_65, 8'h01);
        run_cmd(48'h69_40000000_77, 8'h00);

        // Reset in the middle of the R1 byte
        send_frame(48'h40_00000000_95, 8'h01);
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, bit_rx);
        check("busy_mid_resp", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_miso", 64'(miso), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cmd", 64'(cmd), 64'd0);
        repeat (4) @(negedge clk);
        run_cmd(48'h40_00000000_95, 8'h01);

        for (int t = 0; t < 8; t++) begin
            logic [39:0] body;
            logic [7:0]  c;
            body = {2'b01, 6'($urandom), 32'($urandom)};
            c    = {ref_crc7(body), 1'b1};
            if ($urandom_range(0, 3) == 0) c = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                cs = 1'b1;
                repeat (12) @(negedge clk);
                cs = 1'b0;
                repeat (4) @(negedge clk);
            end
            run_cmd({body, c}, 8'($urandom));
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        check("total_pulses", 64'(pulses), 64'(frames));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdc_spi_responder.md
Name: sdc_spi_responder

Overview:
SPI-mode SD-card responder: the card-side end of the SD command link driven by the host command engine.
- Receives the 48-bit command frame (cmd, arg, crc) on MOSI.
- Presents the decoded frame to card-side logic.
- Returns an R1 byte on MISO after a programmable NCR gap.
- Used as a synthesizable card model in host-side benches and on-board loopback tests. SPI mode 0; all logic runs on the system clock, which oversamples SCLK.

Parameters:
N_CR, 1, number of 0xFF filler bytes between the frame end bit and the R1 byte (legal 1..8)
SYNC_STAGES, 2, synchronizer flops on i_sclk/i_cs/i_mosi (legal 2..3)

Ports:
i_clk  in  1  system clock; f(i_clk) >= 8 x f(SCLK)
i_rst  in  1  synchronous, active-high reset
i_sclk  in  1  SPI clock from host, idle low
i_cs  in  1  chip select from host, active low
i_mosi  in  1  host-to-card data
o_miso  out  1  card-to-host data, idle high
o_cmd  out  8  first frame byte (start, tx bit, 6-bit index), e.g. 0x40 for CMD0
o_arg  out  32  argument, MSB first as received
o_crc  out  8  last frame byte (CRC7 + end bit)
o_cmd_valid  out  1  one-cycle pulse, frame complete; o_cmd/o_arg/o_crc valid from this cycle until next pulse
i_r1  in  8  response byte from card logic, sampled once per frame (see Behaviour)
o_busy  out  1  high from start bit detected until last R1 bit shifted out

Behaviour:
- Reset: o_miso=1, o_cmd=0, o_arg=0, o_crc=0, o_cmd_valid=0, o_busy=0, FSM=IDLE, all counters 0.
- Inputs pass through SYNC_STAGES flops. sclk_rise/sclk_fall are one-cycle strobes from the last two synchronized SCLK samples. MOSI is taken from the same synchronized stage as SCLK.
- All shifting is qualified by synchronized CS low. CS high in any state: return to IDLE next cycle, o_miso=1, o_busy=0, no o_cmd_valid, partial frame discarded.
- IDLE: on sclk_rise with MOSI=0 (start bit), go to RECV with bit count 1. Leading 1 bits (host 0xFF dummies) are ignored.
- RECV: shift MOSI on each sclk_rise into a 48-bit register.
  - At bit 48: latch o_cmd/o_arg/o_crc, pulse o_cmd_valid the following cycle, go to NCR.
  - A frame whose second bit (tx bit) is 0 is still completed; card logic decides via i_r1.
- NCR: o_miso=1, count N_CR*8 sclk_rise edges.
  - i_r1 is sampled on the sclk_rise that completes the final NCR bit; card logic has at least N_CR*8 SCLK periods after o_cmd_valid.
  - On the next sclk_fall, drive R1 bit7 and go to RESP.
- RESP: each subsequent sclk_fall shifts out the next bit, MSB first. After the sclk_rise sampling bit0, on the next sclk_fall o_miso returns to 1 and FSM goes to IDLE.
- MOSI is ignored during NCR and RESP. A new start bit is only recognized in IDLE.
- Latency: SCLK pin edge to internal strobe = SYNC_STAGES+1 i_clk cycles; MISO update one i_clk after sclk_fall strobe.
- Simultaneous CS rise and sclk edge: CS wins.
- i_rst while busy: immediate reset-state values on the next clock, regardless of CS.

Optional Feature:
SDC_CRC_CHECK_EN
- Defined:
  - CRC7 (poly x^7+x^3+1, init 0) is computed serially over frame bits 1..40.
  - At frame end, mismatch against o_crc[7:1] or end bit o_crc[0]=0 sets bit3 (COM_CRC_ERR) of the transmitted R1, OR-ed onto sampled i_r1.
  - Also exposes o_crc_err (out, 1), held with the frame until the next o_cmd_valid; reset 0.
- Undefined: no CRC logic, no o_crc_err port, i_r1 is transmitted unmodified.

Decomposition:
- Shared package sdc_pkg:
  - FSM state encoding (IDLE, RECV, NCR, RESP).
  - Frame length 48, R1 bit positions (IDLE=0, ERASE_RST=1, ILL_CMD=2, COM_CRC_ERR=3, ERASE_SEQ=4, ADDR_ERR=5, PARAM_ERR=6).
  - CRC7 polynomial constant.
  - Command byte constants CMD0=0x40, CMD8=0x48, CMD55=0x77, ACMD41=0x69.
- One natural sub-module, sdc_crc7: serial CRC7 with clear and enable, shared with the host side. It is instantiated only under SDC_CRC_CHECK_EN.

Test Plan:
1. CS low; MOSI 0xFF, then 40 00 00 00 00 95; i_r1=0x01 -> single o_cmd_valid; o_cmd=0x40, o_arg=0, o_crc=0x95; MISO reads N_CR x 0xFF then 0x01; o_busy low after.
2. CMD8 frame 48 00 00 01 AA 87, N_CR=8, i_r1=0x01 -> o_arg=0x000001AA; exactly 8 filler bytes of 0xFF, then 0x01.
3. CS raised after 20 bits of a CMD0 frame, then a full CMD55 frame 77 00 00 00 00 65 -> no pulse for the aborted frame; one pulse with o_cmd=0x77; MISO idle 1 during the abort.
4. With SDC_CRC_CHECK_EN, CMD0 with crc 0x94, i_r1=0x01 -> o_crc_err=1, MISO R1=0x09. With crc 0x95 -> o_crc_err=0, R1=0x01. Without the macro, crc 0x94 -> R1=0x01.
5. Back-to-back CMD55 then ACMD41 (69 40 00 00 00 77) with i_r1 changed between frames (0x01 then 0x00) -> two pulses; the R1 bytes are 0x01 and 0x00 in order.
6. i_rst asserted mid-RESP -> next cycle o_miso=1, o_busy=0; a following CMD0 is received normally.
